// File: rtl/xif_initiator.sv
// Single-outstanding initiator for the split request/response CSR bus.
// One command is captured, run on the bus with a bounded ack/resp wait, and returned as one result.
module xif_initiator #(
  parameter int TIMEOUT  = 1024,
  parameter int TO_CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [3:0]  cmd_be_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_we_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_bo,
  output logic [3:0]  bus_be_bo,
  output logic [31:0] bus_wdata_bo,
  input  logic        bus_ack_i,
  input  logic        bus_resp_i,
  input  logic [31:0] bus_rdata_bi
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  localparam logic [TO_CNT_W-1:0] CntLast = TO_CNT_W'(TIMEOUT - 1);

  state_t              state_q;
  logic [TO_CNT_W-1:0] cnt_q;
  logic [TO_CNT_W-1:0] cnt_d;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                bus_req_q;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      bus_req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            we_q        <= cmd_we_i;
            addr_q      <= cmd_addr_i;
            be_q        <= cmd_be_i;
            wdata_q     <= cmd_wdata_i;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            bus_req_q   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // Ack is checked before the timeout so an ack in the last cycle still succeeds.
          if (bus_ack_i) begin
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
            if (we_q) begin
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= WAIT_RESP;
            end
          end else if (cnt_q == CntLast) begin
            bus_req_q   <= 1'b0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_RESP: begin
          if (bus_resp_i) begin
            rdata_q     <= bus_rdata_bi;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q == CntLast) begin
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign rsp_we_o     = we_q;
  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = we_q;
  assign bus_addr_bo  = addr_q;
  assign bus_be_bo    = be_q;
  assign bus_wdata_bo = wdata_q;

endmodule

// File: tb/tb_xif_initiator.sv
// Scoreboard bench for xif_initiator: randomized commands against a bus responder model,
// expected results derived from the ack/resp delays and the timeout rule.
module tb_xif_initiator;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        arst_n_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_be_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_we_o;
  logic [31:0] rsp_rdata_o;
  logic        bus_req_o, bus_we_o, bus_ack_i, bus_resp_i;
  logic [31:0] bus_addr_bo, bus_wdata_bo, bus_rdata_bi;
  logic [3:0]  bus_be_bo;

  xif_initiator #(.TIMEOUT(TO), .TO_CNT_W(16)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_bo(bus_addr_bo),
    .bus_be_bo(bus_be_bo), .bus_wdata_bo(bus_wdata_bo),
    .bus_ack_i(bus_ack_i), .bus_resp_i(bus_resp_i), .bus_rdata_bi(bus_rdata_bi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          reqlen;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Responder plan for the next transaction: ack after a req cycles, resp r cycles after ack.
  int          plan_ack = 0;
  int          plan_resp = 1;
  logic [31:0] plan_rdata = '0;
  bit          stray_en = 1'b0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t model(logic we, logic [31:0] addr, logic [3:0] be, logic [31:0] wd,
                                 int a, int r, logic [31:0] rd);
    exp_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wd;
    e.err = 1'b1; e.rdata = '0;
    e.reqlen = (a < TO) ? a + 1 : TO;
    if (a < TO) begin
      if (we) e.err = 1'b0;
      else if (r <= TO) begin
        e.err = 1'b0;
        e.rdata = rd;
      end
    end
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // Bus responder, driven just after each rising edge.
  initial begin
    bit prev_req = 1'b0, pend = 1'b0;
    int rc = 0, req_cyc = 0, tgt = 0;
    logic [31:0] tgt_rd = '0;
    bus_ack_i = 1'b0; bus_resp_i = 1'b0; bus_rdata_bi = '0;
    forever begin
      cycle();
      bus_ack_i = 1'b0; bus_resp_i = 1'b0; bus_rdata_bi = $urandom;
      if (pend) begin
        rc++;
        if (rc == tgt) begin
          bus_resp_i = 1'b1; bus_rdata_bi = tgt_rd; pend = 1'b0;
        end
      end else if (stray_en && $urandom_range(3) == 0) bus_resp_i = 1'b1;
      if (bus_req_o) begin
        req_cyc = prev_req ? req_cyc + 1 : 0;
        if (req_cyc == plan_ack) begin
          bus_ack_i = 1'b1;
          if (!bus_we_o) begin
            pend = 1'b1; rc = 0; tgt = plan_resp; tgt_rd = plan_rdata;
          end
        end
      end else if (stray_en && $urandom_range(3) == 0) bus_ack_i = 1'b1;
      prev_req = bus_req_o;
    end
  end

  // Monitor: bus fields during every req cycle, results at every response handshake.
  initial begin
    int reqcnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!arst_n_i) begin
        sb.delete();
        reqcnt = 0;
      end else begin
        if (bus_req_o) begin
          reqcnt++;
          chk("bus_req_has_cmd", sb.size() != 0, 1);
          if (sb.size() != 0)
            chk("bus_fields", {bus_we_o, bus_be_bo, bus_addr_bo, bus_wdata_bo},
                {sb[0].we, sb[0].be, sb[0].addr, sb[0].wdata});
        end
        if (rsp_valid_o && rsp_ready_i) begin
          chk("rsp_has_cmd", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_fields", {rsp_we_o, rsp_err_o, rsp_rdata_o}, {e.we, e.err, e.rdata});
            chk("req_cycles", reqcnt, e.reqlen);
          end
          reqcnt = 0;
        end
      end
    end
  end

  task automatic drive_cmd(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_be_i = be; cmd_wdata_i = wd;
  endtask

  task automatic wait_accept(output bit acc);
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = cmd_ready_o;
      cycle();
    end
    cmd_valid_i = 1'b0; cmd_we_i = $urandom; cmd_addr_i = $urandom;
    cmd_be_i = $urandom; cmd_wdata_i = $urandom;
    chk("cmd_accept", acc, 1);
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input int a, input int r, input logic [31:0] rd,
                      input bit rdy_all, output int ncyc);
    bit acc, done;
    done = 1'b0;
    plan_ack = a; plan_resp = r; plan_rdata = rd;
    sb.push_back(model(we, addr, be, wd, a, r, rd));
    drive_cmd(we, addr, be, wd);
    wait_accept(acc);
    ncyc = 2;
    for (int c = 0; c < 100 && !done; c++) begin
      rsp_ready_i = rdy_all || ($urandom_range(2) != 0);
      @(negedge clk);
      done = rsp_valid_o && rsp_ready_i;
      cycle();
      ncyc++;
    end
    rsp_ready_i = 1'b0;
    chk("rsp_handshake", done, 1);
    for (int c = 0; c < 4 && !cmd_ready_o; c++) begin
      cycle();
      ncyc++;
    end
  endtask

  initial begin
    int n;
    bit acc;
    logic [32:0] snap;
    arst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0;
    cmd_be_i = '0; cmd_wdata_i = '0; rsp_ready_i = 1'b0;
    repeat (3) cycle();
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_outputs", {rsp_valid_o, rsp_err_o, rsp_we_o, rsp_rdata_o, bus_req_o, bus_we_o,
                        bus_addr_bo, bus_be_bo, bus_wdata_bo}, 0);
    arst_n_i = 1'b1;
    cycle();

    send(1'b1, 32'h8000_0000, 4'hF, 32'hA5A5_0001, 0, 1, 32'h0, 1'b1, n);
    chk("wr_cycles_per_cmd", n, 4);
    send(1'b0, 32'h8000_0004, 4'hF, 32'h0, 0, 1, 32'h1234_5678, 1'b1, n);
    chk("rd_cycles_per_cmd", n, 5);
    send(1'b1, 32'h8000_0008, 4'h3, 32'h0BAD_F00D, 3, 1, 32'h0, 1'b0, n);
    send(1'b1, 32'h8000_000C, 4'hF, 32'h1111_2222, 1000, 1, 32'h0, 1'b0, n);
    send(1'b1, 32'h8000_0010, 4'hF, 32'h3333_4444, TO - 1, 1, 32'h0, 1'b0, n);
    send(1'b0, 32'h8000_0014, 4'hF, 32'h0, 0, TO, 32'h5555_6666, 1'b0, n);
    send(1'b0, 32'h8000_0018, 4'hF, 32'h0, 0, TO + 1, 32'hDEAD_BEEF, 1'b0, n);
    send(1'b0, 32'h8000_001C, 4'hF, 32'h0, 0, 1, 32'h0000_0001, 1'b0, n);
    send(1'b0, 32'h8000_0020, 4'h1, 32'h0, 2, 1000, 32'h7777_8888, 1'b0, n);

    stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int a, r;
      a = ($urandom_range(3) == 0) ? $urandom_range(TO + 2, TO - 1) : $urandom_range(3, 0);
      r = ($urandom_range(3) == 0) ? $urandom_range(TO + 2, TO - 1) : $urandom_range(3, 1);
      send($urandom_range(1), $urandom, $urandom, $urandom, a, r, $urandom, 1'b0, n);
      repeat ($urandom_range(2)) cycle();
    end
    stray_en = 1'b0;

    // Result held under backpressure with a new command waiting, then reset during its REQ.
    plan_ack = 0; plan_resp = 1; plan_rdata = 32'hCAFE_0001;
    sb.push_back(model(1'b0, 32'h8000_0100, 4'h3, 32'h0, 0, 1, 32'hCAFE_0001));
    drive_cmd(1'b0, 32'h8000_0100, 4'h3, 32'h0);
    wait_accept(acc);
    for (int c = 0; c < 20 && !rsp_valid_o; c++) cycle();
    chk("hold_rsp_valid", rsp_valid_o, 1);
    snap = {rsp_err_o, rsp_rdata_o};
    chk("hold_rsp_value", snap, {1'b0, 32'hCAFE_0001});
    plan_ack = 1000;
    sb.push_back(model(1'b1, 32'h8000_0200, 4'hC, 32'h9999_0000, 1000, 1, 32'h0));
    drive_cmd(1'b1, 32'h8000_0200, 4'hC, 32'h9999_0000);
    repeat (5) begin
      @(negedge clk);
      chk("hold_rsp_stable", {rsp_valid_o, rsp_we_o, rsp_err_o, rsp_rdata_o}, {2'b10, snap});
      chk("hold_ready_req_low", {cmd_ready_o, bus_req_o}, 0);
      cycle();
    end
    rsp_ready_i = 1'b1;
    cycle();
    rsp_ready_i = 1'b0;
    cycle();
    cmd_valid_i = 1'b0;
    chk("abort_req_high", bus_req_o, 1);
    arst_n_i = 1'b0;
    #1;
    chk("abort_async_outputs", {bus_req_o, cmd_ready_o, rsp_valid_o}, 3'b010);
    repeat (2) cycle();
    arst_n_i = 1'b1;
    repeat (3) begin
      cycle();
      chk("post_reset_idle", {bus_req_o, rsp_valid_o, cmd_ready_o}, 3'b001);
    end
    send(1'b1, 32'h8000_0300, 4'hF, 32'h0123_4567, 0, 1, 32'h0, 1'b1, n);
    chk("post_reset_wr_cycles", n, 4);

    repeat (2) cycle();
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xif_initiator.md
Name: xif_initiator

Overview:
- Single-outstanding bus initiator for the MemSplit32-style split request/response bus (req/we/addr/be/wdata out; ack/resp/rdata in).
- It is the initiator counterpart to the CSR responders on the tile's xif port.
- It accepts one command at a time on a valid/ready command port, runs the bus transaction, and returns the read data or a timeout error on a valid/ready result port.
- Intended use: an accelerator or test-sequencer side needs to drive CSR peripherals without going through UDM.

Parameters:
- TIMEOUT, 1024: cycles to wait for ack (phase A) or resp (phase R) before aborting; legal range ≥2.
- TO_CNT_W, 16: width of the timeout counter; must satisfy 2^TO_CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- arst_n_i  in  1  reset; asynchronous assert, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid and ready are both high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  32  byte address, passed through unmodified.
- cmd_be_i  in  4  byte enables.
- cmd_wdata_i  in  32  write data.
- rsp_valid_o  out  1  result present.
- rsp_ready_i  in  1  result consumed when valid and ready are both high.
- rsp_rdata_o  out  32  read data; 0 for writes and on error.
- rsp_err_o  out  1  transaction timed out.
- rsp_we_o  out  1  echo of the command direction.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write enable.
- bus_addr_bo  out  32  bus address.
- bus_be_bo  out  4  bus byte enables.
- bus_wdata_bo  out  32  bus write data.
- bus_ack_i  in  1  request accepted; valid only while bus_req_o is high.
- bus_resp_i  in  1  read data valid.
- bus_rdata_bi  in  32  read data.

Behaviour:
- Reset (arst_n_i low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, except cmd_ready_o = 1.
  - Timeout counter and captured registers are cleared.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, capture we/addr/be/wdata into registers, clear the counter, go to REQ.
  - bus_req_o rises on the following cycle; the command-to-bus latency is 1 cycle.
- REQ:
  - bus_req_o = 1. bus_we_o, bus_addr_bo, bus_be_bo and bus_wdata_bo show the captured values and stay stable until ack.
  - bus_ack_i high: drop bus_req_o on the next cycle.
    - Write: go to DONE with rdata = 0, err = 0.
    - Read: clear the counter, go to WAIT_RESP.
  - No ack: increment the counter. If the counter = TIMEOUT-1 and there is no ack, go to DONE with err = 1 and rdata = 0.
  - bus_req_o is high for exactly TIMEOUT cycles at most.
  - Ack in the final cycle wins over timeout.
- WAIT_RESP:
  - bus_req_o = 0.
  - bus_resp_i high: capture bus_rdata_bi, go to DONE with err = 0.
  - resp is expected at least 1 cycle after ack. resp in the same cycle as ack (while in REQ) is ignored.
  - Timeout works as in REQ: counter = TIMEOUT-1 with no resp gives DONE with err = 1. resp in the final cycle wins.
- DONE:
  - rsp_valid_o = 1. rsp_rdata_o, rsp_err_o and rsp_we_o are held stable.
  - cmd_ready_o = 0.
  - On rsp_ready_i, go to IDLE; cmd_ready_o = 1 on the next cycle.
  - Minimum occupancy is 1 cycle, so a new command is accepted at the earliest 1 cycle after the response handshake.
- Throughput: zero-wait write = 4 cycles per command (IDLE, REQ, DONE, IDLE); zero-wait read = 5 cycles.
- Stray or late events:
  - bus_resp_i outside WAIT_RESP is ignored.
  - bus_ack_i while bus_req_o = 0 is ignored.
  - A resp arriving after a read timeout does not corrupt the held or next result.
- cmd_valid_i while cmd_ready_o = 0: the command is not consumed and the inputs are not sampled.
- Reset mid-transaction: bus_req_o drops immediately (asynchronously). Any pending result is discarded and nothing is replayed.
- The design contains no combinational path from any input to any output, except through the asynchronous reset.

Test Plan:
- Write addr 0x80000000, be 0xF, wdata 0xA5A5_0001; responder acks at the first req cycle -> exactly one req cycle with stable addr/wdata; rsp_valid_o with err = 0, rdata = 0, we = 1; 4 cycles from command acceptance back to cmd_ready_o.
- Read 0x80000004; ack at the first req cycle, resp + 0x1234_5678 one cycle later -> rsp_rdata_o = 0x1234_5678, err = 0.
- Write with ack delayed 3 cycles -> bus_req_o high exactly 4 cycles with all signals stable; a single response is produced.
- TIMEOUT = 8, no ack -> req high 8 cycles then low; err = 1, rdata = 0. Repeat with ack on the 8th cycle -> success, no error.
- TIMEOUT = 8, read acked, resp never arrives -> err = 1 after 8 cycles in WAIT_RESP. A late resp with 0xDEAD_BEEF, then a new read returning 0x1 -> second result = 0x1.
- Hold rsp_ready_i low 5 cycles with cmd_valid_i high -> rsp fields stable, cmd_ready_o = 0, no bus_req_o. Then assert arst_n_i low during REQ of the next command -> bus_req_o = 0 immediately, cmd_ready_o = 1, rsp_valid_o = 0.
